// File: rtl/rat_int_ctrl.sv
// rtl/rat_int_ctrl.sv - multi-channel edge/level interrupt controller on the RAT port I/O bus
module rat_int_ctrl #(
  parameter int          NUM_CH  = 8,
  parameter logic [7:0]  BASE_ID = 8'hF0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] IRQ_IN,
  input  logic [7:0]        PORT_ID,
  input  logic [7:0]        OUT_PORT,
  input  logic              IO_STRB,
  output logic [7:0]        RD_DATA,
  output logic              RD_HIT,
  output logic              INT
);

  logic [NUM_CH-1:0] s1, s2, prv;
  logic [NUM_CH-1:0] pend, mask, mode;
  logic [NUM_CH-1:0] rise, w1c, clr_all, act, pend_nxt;
  logic              gie;
  logic [7:0]        offset;
  logic              wr;
  logic [7:0]        vec;

  function automatic logic [7:0] widen(input logic [NUM_CH-1:0] v);
    logic [7:0] r;
    r = '0;
    r[NUM_CH-1:0] = v;
    return r;
  endfunction

  // BASE_ID <= 8'hFB, so addresses below BASE_ID wrap to large offsets and miss
  assign offset = PORT_ID - BASE_ID;
  assign RD_HIT = offset < 8'd5;
  assign wr     = IO_STRB & RD_HIT;

  assign rise    = s2 & ~prv;
  assign w1c     = (wr && offset == 8'd0) ? OUT_PORT[NUM_CH-1:0] : '0;
  assign clr_all = {NUM_CH{wr && offset == 8'd4 && OUT_PORT[1]}};
  // Edge bits: a coincident rising edge overrides any clear; level bits mirror s2
  assign pend_nxt = (mode & ((pend & ~w1c & ~clr_all) | rise)) | (~mode & s2);
  assign act      = pend & mask;

  always_comb begin
    vec = 8'hFF;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (act[i]) vec = 8'(i);
    end
  end

  always_comb begin
    RD_DATA = '0;
    case (offset)
      8'd0:    RD_DATA = widen(pend);
      8'd1:    RD_DATA = widen(mask);
      8'd2:    RD_DATA = widen(mode);
      8'd3:    RD_DATA = vec;
      8'd4:    RD_DATA = {7'b0, gie};
      default: RD_DATA = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1   <= '0;
      s2   <= '0;
      prv  <= '0;
      pend <= '0;
      mask <= '0;
      mode <= '0;
      gie  <= 1'b0;
      INT  <= 1'b0;
    end else begin
      s1   <= IRQ_IN;
      s2   <= s1;
      prv  <= s2;
      pend <= pend_nxt;
      if (wr && offset == 8'd1) mask <= OUT_PORT[NUM_CH-1:0];
      if (wr && offset == 8'd2) mode <= OUT_PORT[NUM_CH-1:0];
      if (wr && offset == 8'd4) gie  <= OUT_PORT[0];
      INT  <= gie & (|act);
    end
  end

endmodule

// File: doc/rat_int_ctrl.md
# rat_int_ctrl

Parametrised, multi-channel interrupt controller for the RAT MCU. It collects up to eight external interrupt sources and applies per-channel edge/level mode, masking and fixed priority. It drives the MCU's single `INT` input. Software reaches its registers through the existing port I/O path: `PORT_ID`, `OUT_PORT`, `IO_STRB` and the `IN_PORT` mux.

## Interface
Parameters:
- `NUM_CH`, 8, number of interrupt channels; legal range 1..8.
- `BASE_ID`, 8'hF0, port ID of register 0; registers occupy `BASE_ID`..`BASE_ID+4`. `BASE_ID` must be ≤ 8'hFB.

Ports:
- `CLK`, input, 1, system clock; all state updates on its rising edge.
- `RESET_N`, input, 1, asynchronous, active-low reset.
- `IRQ_IN`, input, `NUM_CH`, raw interrupt requests, asynchronous to `CLK`.
- `PORT_ID`, input, 8, MCU port address.
- `OUT_PORT`, input, 8, MCU write data.
- `IO_STRB`, input, 1, MCU write strobe; one cycle wide.
- `RD_DATA`, output, 8, register read data, muxed into the MCU `IN_PORT`.
- `RD_HIT`, output, 1, high when `PORT_ID` addresses one of the five registers.
- `INT`, output, 1, registered interrupt request to the MCU.

## Operation
Input conditioning:
- Each channel passes through a 2-flop synchroniser (`s1`, `s2`) and then a history flop `prv`.
- A rising edge is detected as `s2 & ~prv`.

Registers (offset from `BASE_ID`). Bits ≥ `NUM_CH` read 0 and ignore writes.
- +0 PEND:
  - Read: pending bits.
  - Write: write-1-to-clear.
  - Edge-mode channel: bit sets on a detected rising edge; it clears only by a W1C write or reset.
  - Level-mode channel: bit loads `s2` every cycle, so W1C has no lasting effect.
- +1 MASK: R/W; 1 enables the channel. Masked channels still update PEND.
- +2 MODE: R/W; 1 selects edge mode, 0 selects level mode.
- +3 VEC: read-only; index of the lowest-numbered bit set in PEND&MASK, or 8'hFF if none. Writes are ignored.
- +4 CTRL:
  - bit0 GIE (global enable), R/W.
  - bit1 CLRALL: a write of 1 clears all edge-mode PEND bits; the bit always reads 0.
  - Other bits read 0.

Rules:
- A write occurs only when `IO_STRB`=1 and `PORT_ID` matches.
- Reads are purely combinational on `PORT_ID` and have no side effects.
- `RD_DATA` = 0 when `RD_HIT`=0.
- If a rising edge and a W1C for the same bit fall in the same cycle, the set wins and the bit stays 1.
- If MODE switches level→edge, PEND keeps its current value. If it switches edge→level, PEND follows `s2` from the next edge.
- `INT` next-state = GIE & |(PEND & MASK), registered.

Reset (`RESET_N`=0, asynchronous):
- All flops clear: `s1`, `s2`, `prv`, PEND, MASK, MODE and GIE all read 0, and `INT`=0.
- Consequently VEC reads 8'hFF and `RD_DATA` shows reset values.
- Reset asserted mid-operation discards pending requests immediately.
- The first edge after release samples normally. An `IRQ_IN` that is high across reset release is seen as a rising edge, because `prv` resets to 0.

## Timing
- `IRQ_IN` rises with setup before edge E1:
  - `s1` at E1, `s2` at E2;
  - PEND set at E3 (edge mode) or E3 (level mode);
  - `INT` high after E4.
  - Worst-case latency is 4 cycles.
- Register writes take effect at the `IO_STRB` edge. `INT` reflects the new state one edge later, e.g. after a W1C of the last pending bit, `INT` falls 1 cycle after the strobe edge.
- `RD_DATA`/`RD_HIT` settle combinationally within the same cycle as `PORT_ID`. VEC follows PEND/MASK with no extra delay.
- Level-mode deassertion: `IRQ_IN` falls before E1, PEND clears at E3, `INT` drops after E4.
- Edge pulses shorter than one `CLK` period may be missed. Sources must hold for at least 2 cycles.

## Test plan
- Reset: hold `RESET_N`=0 with `IRQ_IN`=8'hFF. Required: `INT`=0; reads of PEND/MASK/MODE/CTRL = 0 and VEC = 8'hFF. After release, with MODE=0, PEND = 8'hFF by cycle 3 and `INT` stays 0 because GIE=0.
- Edge latch and priority:
  - Write MODE=8'hFF, MASK=8'h28, CTRL=1.
  - Pulse ch5 then ch3 (3 cycles each). Required: PEND=8'h28, VEC=3, `INT`=1.
  - W1C 8'h08: VEC=5.
  - W1C 8'h20: `INT`=0 one cycle later.
- Simultaneous set/clear: an edge on ch0 coincident with a W1C write of 8'h01 on the same edge → PEND[0] stays 1 and `INT` remains asserted.
- Level mode: MODE=0, MASK=8'h01, GIE=1, `IRQ_IN`[0] held high.
  - W1C 8'h01: PEND[0] reads 1 again next cycle.
  - Drop `IRQ_IN`[0]: `INT` falls 4 cycles later.
- Masking and CLRALL:
  - Pend ch2 with MASK=0: `INT`=0, VEC=8'hFF, PEND=8'h04.
  - Set MASK=8'h04: `INT`=1 within 1 cycle.
  - Write CTRL=8'h03: PEND=0 and `INT`=0 next cycle.
- Decode/parameter: with `NUM_CH`=3 and `BASE_ID`=8'h40:
  - `PORT_ID`=8'h45 gives `RD_HIT`=0 and `RD_DATA`=0.
  - Writing MASK=8'hFF reads back 8'h07.
  - `IRQ_IN` width is 3.
